// File: rtl/z16_button_conditioner.sv
// z16_button_conditioner
// Conditions the raw board push-button before it reaches the Z16 CPU.
// The pin is normalised to active-high, passed through a two-flop
// synchroniser, debounced with a stability counter, and turned into a
// clean level, one-cycle press/release strobes, a sticky press-pending
// flag (cleared by the consumer's acknowledge) and a wrapping press counter.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable synchronised samples needed to accept a new level
//                    (legal range 2 .. 2**CNT_W-1)
//   CNT_W            debounce counter width
//   PIN_ACTIVE_LOW   1 = pin reads 0 when pressed, 0 = pin reads 1 when pressed
//
// Ports:
//   i_clk          system clock, all state on the rising edge
//   i_rst          asynchronous reset, active-low
//   i_button       raw board pin, asynchronous
//   i_ack          consumer acknowledge, clears o_pending
//   o_level        debounced button state, 1 = pressed
//   o_press        one-cycle strobe on an accepted press
//   o_release      one-cycle strobe on an accepted release
//   o_pending      sticky: a press occurred and is not yet acknowledged
//   o_press_count  accepted-press counter, wraps 255 -> 0

module z16_button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 270000,
   parameter int CNT_W           = 20,
   parameter bit PIN_ACTIVE_LOW  = 1'b1
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_button,
   input  logic       i_ack,
   output logic       o_level,
   output logic       o_press,
   output logic       o_release,
   output logic       o_pending,
   output logic [7:0] o_press_count
);

   typedef enum logic [1:0] {
      RELEASED,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT
   } state_t;

   // The counter reaching this value on a still-stable sample is the
   // DEBOUNCE_CYCLES-th consecutive sample of the new level.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             pin_pressed;
   logic             sync_meta;
   logic             sync_s;
   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_next;
   logic             press_next;
   logic             release_next;

   // Normalise the pin so that 1 always means "pressed" from here on.
   assign pin_pressed = PIN_ACTIVE_LOW ? ~i_button : i_button;

   // Two-flop synchroniser. Reset loads the released value so that leaving
   // reset never looks like a level change.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         sync_meta <= 1'b0;
         sync_s    <= 1'b0;
      end else begin
         sync_meta <= pin_pressed;
         sync_s    <= sync_meta;
      end
   end

   // Debounce state and stability counter. The strobes are registered on
   // the same edge that enters the new stable state, so each one lines up
   // with the first cycle of the new o_level value.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state     <= RELEASED;
         count     <= '0;
         o_press   <= 1'b0;
         o_release <= 1'b0;
      end else begin
         state     <= state_next;
         count     <= count_next;
         o_press   <= press_next;
         o_release <= release_next;
      end
   end

   // Next-state logic. The wait states count consecutive samples of the
   // candidate level; any sample of the old level abandons the attempt and
   // returns to the stable state with the counter cleared, which is what
   // makes short glitches invisible at the output.
   always_comb begin
      state_next   = state;
      count_next   = count;
      press_next   = 1'b0;
      release_next = 1'b0;
      case (state)
         RELEASED: begin
            if (sync_s) begin
               state_next = PRESS_WAIT;
               count_next = CNT_ONE;
            end
         end
         PRESS_WAIT: begin
            if (!sync_s) begin
               state_next = RELEASED;
               count_next = '0;
            end else if (count == CNT_LAST) begin
               state_next = PRESSED;
               count_next = '0;
               press_next = 1'b1;
            end else begin
               count_next = count + CNT_ONE;
            end
         end
         PRESSED: begin
            if (!sync_s) begin
               state_next = RELEASE_WAIT;
               count_next = CNT_ONE;
            end
         end
         RELEASE_WAIT: begin
            if (sync_s) begin
               state_next = PRESSED;
               count_next = '0;
            end else if (count == CNT_LAST) begin
               state_next   = RELEASED;
               count_next   = '0;
               release_next = 1'b1;
            end else begin
               count_next = count + CNT_ONE;
            end
         end
         default: begin
            state_next = RELEASED;
            count_next = '0;
         end
      endcase
   end

   // The debounced level is pressed throughout PRESSED and while a release
   // is still being qualified.
   assign o_level = (state == PRESSED) || (state == RELEASE_WAIT);

   // Consumer-facing bookkeeping, driven by the strobe during its cycle.
   // A press arriving together with an acknowledge keeps the flag set so
   // that the new press is never lost.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         o_pending     <= 1'b0;
         o_press_count <= 8'd0;
      end else begin
         if (o_press) begin
            o_pending     <= 1'b1;
            o_press_count <= o_press_count + 8'd1;
         end else if (i_ack) begin
            o_pending <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_z16_button_conditioner.sv
// Testbench for z16_button_conditioner with DEBOUNCE_CYCLES=8 and an
// active-low pin. A behavioural model tracks how long the synchronised
// pin has disagreed with the accepted level and flips the level once that
// run reaches DEBOUNCE_CYCLES; strobes, pending flag and press count follow
// from the level changes.

module tb_z16_button_conditioner;

   localparam int D = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       button = 1'b1;
   logic       ack = 1'b0;
   logic       level;
   logic       press;
   logic       release_s;
   logic       pending;
   logic [7:0] press_count;

   int n_total = 0;
   int n_bad = 0;

   // Reference model state.
   bit       m_sync1;
   bit       m_s;
   bit       m_level;
   bit       m_press;
   bit       m_release;
   bit       m_pending;
   int       m_run;
   bit [7:0] m_count;

   always #5 clk = ~clk;

   z16_button_conditioner #(
      .DEBOUNCE_CYCLES(D),
      .CNT_W(4),
      .PIN_ACTIVE_LOW(1'b1)
   ) dut (
      .i_clk(clk),
      .i_rst(rst_n),
      .i_button(button),
      .i_ack(ack),
      .o_level(level),
      .o_press(press),
      .o_release(release_s),
      .o_pending(pending),
      .o_press_count(press_count)
   );

   wire [11:0] dut_vec = {level, press, release_s, pending, press_count};

   function automatic logic [11:0] model_vec();
      return {m_level, m_press, m_release, m_pending, m_count};
   endfunction

   task automatic model_clear();
      m_sync1   = 0;
      m_s       = 0;
      m_level   = 0;
      m_press   = 0;
      m_release = 0;
      m_pending = 0;
      m_run     = 0;
      m_count   = 0;
   endtask

   // Advance the model by one rising edge using the inputs present at it.
   task automatic model_edge();
      if (!rst_n) begin
         model_clear();
      end else begin
         m_count = m_count + 8'(m_press);
         if (m_press) m_pending = 1;
         else if (ack) m_pending = 0;
         m_press   = 0;
         m_release = 0;
         if (m_s != m_level) begin
            m_run++;
            if (m_run == D) begin
               m_level   = !m_level;
               m_run     = 0;
               m_press   = m_level;
               m_release = !m_level;
            end
         end else begin
            m_run = 0;
         end
         m_s     = m_sync1;
         m_sync1 = !button;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      #2;
      rst_n = 1'b0;
      model_clear();
      #1;
      n_total++;
      if (level !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_level got=%b want=0", level); end
      n_total++;
      if (press !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_press got=%b want=0", press); end
      n_total++;
      if (release_s !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_release got=%b want=0", release_s); end
      n_total++;
      if (pending !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_pending got=%b want=0", pending); end
      n_total++;
      if (press_count !== 8'd0) begin n_bad++; $display("[TB] FAIL reset_count got=%0d want=0", press_count); end
      step();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_clean_press();
      int rise = 0;
      int strobes = 0;
      button = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         step();
         n_total++;
         if (dut_vec !== model_vec()) begin
            n_bad++;
            $display("[TB] FAIL clean_press cyc=%0d got=%h want=%h", i, dut_vec, model_vec());
         end
         if (level === 1'b1 && rise == 0) rise = i;
         if (press === 1'b1) strobes++;
      end
      n_total++;
      if (rise != D + 2) begin n_bad++; $display("[TB] FAIL press_latency got=%0d want=%0d", rise, D + 2); end
      n_total++;
      if (strobes != 1) begin n_bad++; $display("[TB] FAIL press_strobe_len got=%0d want=1", strobes); end
      n_total++;
      if (press_count !== 8'd1) begin n_bad++; $display("[TB] FAIL press_count got=%0d want=1", press_count); end
      n_total++;
      if (pending !== 1'b1) begin n_bad++; $display("[TB] FAIL press_pending got=%b want=1", pending); end
   endtask

   task automatic test_release_ack();
      int fall = 0;
      int strobes = 0;
      ack = 1'b1;
      step();
      ack = 1'b0;
      n_total++;
      if (pending !== 1'b0) begin n_bad++; $display("[TB] FAIL ack_clear got=%b want=0", pending); end
      button = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         step();
         n_total++;
         if (dut_vec !== model_vec()) begin
            n_bad++;
            $display("[TB] FAIL release cyc=%0d got=%h want=%h", i, dut_vec, model_vec());
         end
         if (level === 1'b0 && fall == 0) fall = i;
         if (release_s === 1'b1) strobes++;
      end
      n_total++;
      if (fall != D + 2) begin n_bad++; $display("[TB] FAIL release_latency got=%0d want=%0d", fall, D + 2); end
      n_total++;
      if (strobes != 1) begin n_bad++; $display("[TB] FAIL release_strobe_len got=%0d want=1", strobes); end
      n_total++;
      if (press_count !== 8'd1) begin n_bad++; $display("[TB] FAIL release_count got=%0d want=1", press_count); end
   endtask

   task automatic test_bounce();
      int activity = 0;
      for (int i = 0; i < 30; i++) begin
         button = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
         step();
         n_total++;
         if (dut_vec !== model_vec()) begin
            n_bad++;
            $display("[TB] FAIL bounce cyc=%0d got=%h want=%h", i, dut_vec, model_vec());
         end
         if (level !== 1'b0 || press !== 1'b0 || release_s !== 1'b0) activity++;
      end
      button = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step();
         if (level !== 1'b0 || press !== 1'b0 || release_s !== 1'b0) activity++;
      end
      n_total++;
      if (activity != 0) begin n_bad++; $display("[TB] FAIL bounce_quiet got=%0d want=0 active cycles", activity); end
   endtask

   task automatic test_simultaneous();
      button = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         n_total++;
         if (dut_vec !== model_vec()) begin
            n_bad++;
            $display("[TB] FAIL simul cyc=%0d got=%h want=%h", i, dut_vec, model_vec());
         end
         ack = m_press;
      end
      ack = 1'b0;
      n_total++;
      if (pending !== 1'b1) begin n_bad++; $display("[TB] FAIL simul_set_wins got=%b want=1", pending); end
      ack = 1'b1;
      step();
      ack = 1'b0;
      n_total++;
      if (pending !== 1'b0) begin n_bad++; $display("[TB] FAIL simul_second_ack got=%b want=0", pending); end
      button = 1'b1;
      for (int i = 0; i < 14; i++) step();
      n_total++;
      if (dut_vec !== model_vec()) begin n_bad++; $display("[TB] FAIL simul_release got=%h want=%h", dut_vec, model_vec()); end
   endtask

   task automatic test_wrap();
      bit [7:0] start = m_count;
      int errs = 0;
      for (int p = 0; p < 256; p++) begin
         button = 1'b0;
         for (int i = 0; i < 12; i++) begin
            step();
            if (dut_vec !== model_vec()) errs++;
         end
         button = 1'b1;
         for (int i = 0; i < 12; i++) begin
            step();
            if (dut_vec !== model_vec()) errs++;
         end
      end
      n_total++;
      if (errs != 0) begin n_bad++; $display("[TB] FAIL wrap_track got=%0d want=0 mismatching cycles", errs); end
      n_total++;
      if (press_count !== start) begin n_bad++; $display("[TB] FAIL wrap_count got=%0d want=%0d", press_count, start); end
      n_total++;
      if (pending !== 1'b1) begin n_bad++; $display("[TB] FAIL wrap_pending got=%b want=1", pending); end
      ack = 1'b1;
      step();
      ack = 1'b0;
   endtask

   task automatic test_random();
      int errs = 0;
      int hold = 0;
      for (int i = 0; i < 1500; i++) begin
         if (hold == 0) begin
            button = 1'($urandom_range(0, 1));
            hold = $urandom_range(1, 12);
         end
         hold--;
         ack = ($urandom_range(0, 3) == 0);
         step();
         n_total++;
         if (dut_vec !== model_vec()) begin
            n_bad++;
            errs++;
            if (errs < 10) $display("[TB] FAIL random cyc=%0d got=%h want=%h", i, dut_vec, model_vec());
         end
      end
      ack = 1'b0;
   endtask

   task automatic test_reset_mid();
      int rise = 0;
      button = 1'b1;
      for (int i = 0; i < 14; i++) step();
      button = 1'b0;
      for (int i = 0; i < 20 && m_run != 5; i++) step();
      for (int phase = 0; phase < 2; phase++) begin
         rst_n = 1'b0;
         #1;
         n_total++;
         if (dut_vec !== 12'h000) begin n_bad++; $display("[TB] FAIL reset_mid%0d got=%h want=000", phase, dut_vec); end
         model_clear();
         step();
         step();
         @(negedge clk);
         rst_n = 1'b1;
         rise = 0;
         for (int i = 1; i <= 14; i++) begin
            step();
            n_total++;
            if (dut_vec !== model_vec()) begin
               n_bad++;
               $display("[TB] FAIL reset_mid_rerun%0d cyc=%0d got=%h want=%h", phase, i, dut_vec, model_vec());
            end
            if (level === 1'b1 && rise == 0) rise = i;
         end
         n_total++;
         if (rise != D + 2) begin n_bad++; $display("[TB] FAIL reset_mid_latency%0d got=%0d want=%0d", phase, rise, D + 2); end
      end
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      test_reset();
      test_clean_press();
      test_release_ack();
      test_bounce();
      test_simultaneous();
      test_wrap();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
